// File: rtl/pit_xfer_ctrl.sv
// pit_xfer_ctrl: Pending Interest Table transfer controller.
// Stores an interest packet into one slot of PIT packet memory, or on a
// data-return lookup streams that slot back out (hit) or pulses fib_out (miss).
//
// Handshakes: a beat moves on a rising clk edge where valid && ready are both
// high. Valid never depends combinationally on ready. Once out_valid is raised,
// out_data holds until it is accepted. in_ready may drop without a handshake
// once the packet length has been reached.
module pit_xfer_ctrl #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4,
   parameter int LEN_W  = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_bit,
   input  logic                   out_bit,
   input  logic [IDX_W:0]         table_entry,
   input  logic [LEN_W:0]         pkt_len,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [IDX_W+LEN_W-1:0] mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LEN_W:0]         current_byte,
   output logic                   fib_out,
   output logic                   done,
   output logic                   busy
);

   localparam logic [LEN_W:0] SLOT_LEN = {1'b1, {LEN_W{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  slot_q;
   logic [LEN_W:0]    len_q;
   logic [LEN_W:0]    rd_ptr;
   logic [LEN_W:0]    eff_len;
   logic [DATA_W-1:0] skid_data;
   logic              skid_valid;
   logic              wr_fire;
   logic              wr_last;
   logic              rd_accept;
   logic              rd_last;
   logic              rd_issue;

   // Effective length: 0 or anything larger than a slot means a full slot.
   always_comb begin
      eff_len = pkt_len;
      if (pkt_len == '0 || pkt_len > SLOT_LEN)
         eff_len = SLOT_LEN;
   end

   // Beat events. mem_re high means a read issued last edge whose data is on
   // mem_rdata now; the skid register absorbs it if out_data is stalled, and
   // issue is held off while the skid is occupied so nothing is overwritten.
   always_comb begin
      wr_fire   = (state == S_WRITE) && in_valid && (current_byte < len_q);
      wr_last   = wr_fire && (current_byte == len_q - 1'b1);
      rd_accept = (state == S_READ) && out_valid && out_ready;
      rd_last   = rd_accept && (current_byte == len_q - 1'b1);
      rd_issue  = (state == S_READ) && (rd_ptr < len_q) &&
                  (!out_valid || out_ready) && !skid_valid;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: write requests win over read requests; a miss stays idle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (in_bit)                              state_nxt = S_WRITE;
            else if (out_bit && table_entry[IDX_W])  state_nxt = S_READ;
         end
         S_WRITE: if (wr_last) state_nxt = S_DONE;
         S_READ:  if (rd_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      in_ready = (state == S_WRITE) && (current_byte < len_q);
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
   end

   // Datapath: request sampling, memory strobes, output stream and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q       <= '0;
         len_q        <= '0;
         rd_ptr       <= '0;
         current_byte <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         mem_re       <= 1'b0;
         out_data     <= '0;
         out_valid    <= 1'b0;
         skid_data    <= '0;
         skid_valid   <= 1'b0;
         fib_out      <= 1'b0;
      end else begin
         mem_we  <= 1'b0;
         mem_re  <= 1'b0;
         fib_out <= 1'b0;
         case (state)
            S_IDLE: begin
               rd_ptr     <= '0;
               skid_valid <= 1'b0;
               if (in_bit || out_bit) begin
                  slot_q <= table_entry[IDX_W-1:0];
                  len_q  <= eff_len;
               end
               if (in_bit || (out_bit && table_entry[IDX_W]))
                  current_byte <= '0;
               else if (out_bit)
                  fib_out <= 1'b1;
            end
            S_WRITE: begin
               if (wr_fire) begin
                  mem_we       <= 1'b1;
                  mem_addr     <= {slot_q, current_byte[LEN_W-1:0]};
                  mem_wdata    <= in_data;
                  current_byte <= current_byte + 1'b1;
               end
            end
            S_READ: begin
               if (rd_issue) begin
                  mem_re   <= 1'b1;
                  mem_addr <= {slot_q, rd_ptr[LEN_W-1:0]};
                  rd_ptr   <= rd_ptr + 1'b1;
               end
               if (rd_accept)
                  current_byte <= current_byte + 1'b1;
               if (out_valid && !out_ready) begin
                  if (mem_re) begin
                     skid_data  <= mem_rdata;
                     skid_valid <= 1'b1;
                  end
               end else if (skid_valid) begin
                  out_data   <= skid_data;
                  out_valid  <= 1'b1;
                  skid_valid <= 1'b0;
               end else if (mem_re) begin
                  out_data  <= mem_rdata;
                  out_valid <= 1'b1;
               end else begin
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pit_xfer_ctrl.md
Name: pit_xfer_ctrl

Overview:
- Parametrised Pending Interest Table transfer controller for the NDN router.
- Stores an incoming interest packet into a per-entry slot of PIT packet memory.
- On a data-return lookup, either streams the stored slot back out (hit) or flags the FIB path (miss).
- Adds parametrised data/slot/index widths, per-packet length, valid/ready handshakes on both streams, and done/busy status.

Parameters:
- DATA_W, 8, byte-lane width of packet data.
- IDX_W, 4, PIT entry index width; 2**IDX_W slots.
- LEN_W, 10, slot offset width; slot size SLOT_BYTES = 2**LEN_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_bit  in  1  request: store interest packet (write).
- out_bit  in  1  request: look up and return packet (read).
- table_entry  in  IDX_W+1  [IDX_W] = hit flag, [IDX_W-1:0] = slot index.
- pkt_len  in  LEN_W+1  byte count, sampled with the request.
- in_data  in  DATA_W  write stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts in_data.
- mem_addr  out  IDX_W+LEN_W  {slot, offset}.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe; mem_rdata is valid exactly 1 cycle later.
- mem_rdata  in  DATA_W  memory read data.
- out_data  out  DATA_W  read stream byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- current_byte  out  LEN_W+1  bytes transferred in the current operation.
- fib_out  out  1  1-cycle pulse on lookup miss.
- done  out  1  1-cycle pulse on transfer completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async): state = IDLE. in_ready, mem_we, mem_re, out_valid, fib_out, done, busy = 0. mem_addr, mem_wdata, out_data, current_byte = 0. Reset mid-transfer aborts immediately; a partial slot write is not rolled back.
- Effective length L: pkt_len if 1..SLOT_BYTES; pkt_len = 0 or > SLOT_BYTES gives L = SLOT_BYTES.
- IDLE: slot, hit flag and L are sampled at the edge where a request is seen.
  - in_bit and out_bit both high: in_bit wins.
  - in_bit -> WRITE; current_byte cleared.
  - out_bit with hit = 1 -> READ; current_byte cleared.
  - out_bit with hit = 0 -> fib_out = 1 for one cycle; stay IDLE; no memory access.
- WRITE:
  - in_ready = 1 while current_byte < L.
  - Each in_valid && in_ready edge registers mem_we = 1, mem_addr = {slot, current_byte[LEN_W-1:0]}, mem_wdata = in_data, then current_byte += 1.
  - mem_we is 0 on cycles with no handshake.
  - After the L-th beat: in_ready drops, state -> DONE.
- READ:
  - A read issues (registered mem_re = 1, mem_addr = {slot, rd_ptr}) when rd_ptr < L and (!out_valid || out_ready), and no issued read is still pending whose data would overwrite an unaccepted out_data.
  - One cycle after issue: out_data = mem_rdata, out_valid = 1.
  - out_data/out_valid hold until out_valid && out_ready; current_byte += 1 per accepted beat.
  - Throughput is 1 byte/cycle with out_ready held high.
  - When current_byte reaches L and the last beat is accepted: out_valid = 0, state -> DONE.
- DONE: done = 1 for one cycle, busy = 0 on exit, -> IDLE.
- Requests arriving outside IDLE are ignored (not queued).
- Changes to table_entry or pkt_len after sampling have no effect on the operation in progress.
- Offset wraps only within a slot; addresses never cross into slot+1.

Test Plan:
- Write: slot 3, pkt_len 4, bytes 0xA1..0xA4 with in_valid continuous -> mem_we on 4 consecutive cycles at mem_addr 0xC00..0xC03; done pulses once; current_byte = 4.
- Read hit: table_entry = {1, 3}, pkt_len 4, out_ready = 1 -> out_data 0xA1..0xA4 on 4 consecutive out_valid cycles, first 2 cycles after the request edge; done pulses.
- Backpressure: same read with out_ready low for 3 cycles after beat 2 -> beat 2 held stable, no extra mem_re, no byte lost or duplicated.
- Miss and priority:
  - table_entry hit = 0 with out_bit -> fib_out pulse 1 cycle, mem_re never asserted.
  - in_bit and out_bit together -> WRITE taken.
- Length boundaries:
  - pkt_len 0 -> 1024 bytes written, offsets 0..1023, no spill into next slot.
  - pkt_len 1 -> single beat, then done.
- Reset mid-write after 2 beats -> all outputs 0 immediately, state IDLE; a new request then proceeds normally.
